// File: rtl/inst_encoder.sv
// Two-stage RV32I instruction encoder: packs decoded fields into a 32-bit word, range-checks the
// immediate, and tags each emitted word with an incrementing IMEM word address.
module inst_encoder #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned ERR_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_fmt,
  input  logic [6:0]        i_opcode,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [2:0]        i_funct3,
  input  logic [6:0]        i_funct7,
  input  logic [31:0]       i_imm,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [31:0]       o_inst,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_err,
  output logic [ERR_W-1:0]  o_err_cnt
);

  localparam logic [2:0]  FmtR = 3'd0;
  localparam logic [2:0]  FmtI = 3'd1;
  localparam logic [2:0]  FmtS = 3'd2;
  localparam logic [2:0]  FmtB = 3'd3;
  localparam logic [2:0]  FmtU = 3'd4;
  localparam logic [2:0]  FmtJ = 3'd5;
  localparam logic [31:0] Nop  = 32'h0000_0013;

  logic        s1_valid;
  logic [2:0]  s1_fmt;
  logic [6:0]  s1_op;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [2:0]  s1_f3;
  logic [6:0]  s1_f7;
  logic [31:0] s1_imm;
  logic        s1_err;
  logic        err1;
  logic        s2_load;
  logic        accept;
  logic        hs;
  logic [31:0] enc;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [ERR_W-1:0]  err_cnt_d;

  assign s2_load = !o_valid || i_ready;
  assign o_ready = !s1_valid || s2_load;
  assign accept  = i_valid && o_ready;
  assign hs      = o_valid && i_ready;

  // Immediate must be representable as a sign-extended field of the target format.
  always_comb begin
    err1 = 1'b0;
    case (i_fmt)
      FmtR:       err1 = 1'b0;
      FmtI, FmtS: err1 = !((&i_imm[31:11]) || !(|i_imm[31:11]));
      FmtB:       err1 = !((&i_imm[31:12]) || !(|i_imm[31:12])) || i_imm[0];
      FmtU:       err1 = |i_imm[11:0];
      FmtJ:       err1 = !((&i_imm[31:20]) || !(|i_imm[31:20])) || i_imm[0];
      default:    err1 = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      s1_fmt <= i_fmt;
      s1_op  <= i_opcode;
      s1_rd  <= i_rd;
      s1_rs1 <= i_rs1;
      s1_rs2 <= i_rs2;
      s1_f3  <= i_funct3;
      s1_f7  <= i_funct7;
      s1_imm <= i_imm;
      s1_err <= err1;
    end
  end

  always_comb begin
    enc = Nop;
    case (s1_fmt)
      FmtR:    enc = {s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd, s1_op};
      FmtI:    enc = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
      FmtS:    enc = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_op};
      FmtB:    enc = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:1], s1_imm[11],
                      s1_op};
      FmtU:    enc = {s1_imm[31:12], s1_rd, s1_op};
      FmtJ:    enc = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_op};
      default: enc = Nop;
    endcase
    if (s1_err) enc = Nop;
  end

  // A word loading alongside a handshake takes the post-increment (or cleared) address.
  always_comb begin
    addr_d    = addr_q;
    err_cnt_d = o_err_cnt;
    if (i_clear) begin
      addr_d    = '0;
      err_cnt_d = '0;
    end else if (hs) begin
      addr_d = addr_q + ADDR_W'(1);
      if (o_err && !(&o_err_cnt)) err_cnt_d = o_err_cnt + ERR_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid   <= 1'b0;
      o_inst    <= '0;
      o_addr    <= '0;
      o_err     <= 1'b0;
      o_err_cnt <= '0;
      addr_q    <= '0;
    end else begin
      addr_q    <= addr_d;
      o_err_cnt <= err_cnt_d;
      if (s2_load) begin
        o_valid <= s1_valid;
        if (s1_valid) begin
          o_inst <= enc;
          o_err  <= s1_err;
          o_addr <= addr_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: a default-width instance and a narrow-counter instance share
// stimulus; a queue of expected words is checked on every output handshake.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        reset, clear, valid_in, ready_in;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm;

  logic        ready_out, valid_out, err;
  logic [31:0] inst;
  logic [9:0]  addr;
  logic [7:0]  err_cnt;
  logic        s_ready, s_valid, s_err;
  logic [31:0] s_inst;
  logic [1:0]  s_addr;
  logic [1:0]  s_err_cnt;

  inst_encoder dut (
    .i_clk(clk), .i_reset(reset), .i_clear(clear), .i_valid(valid_in), .o_ready(ready_out),
    .i_fmt(fmt), .i_opcode(opcode), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2), .i_funct3(f3),
    .i_funct7(f7), .i_imm(imm), .o_valid(valid_out), .i_ready(ready_in), .o_inst(inst),
    .o_addr(addr), .o_err(err), .o_err_cnt(err_cnt)
  );

  inst_encoder #(.ADDR_W(2), .ERR_W(2)) dut_small (
    .i_clk(clk), .i_reset(reset), .i_clear(clear), .i_valid(valid_in), .o_ready(s_ready),
    .i_fmt(fmt), .i_opcode(opcode), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2), .i_funct3(f3),
    .i_funct7(f7), .i_imm(imm), .o_valid(s_valid), .i_ready(ready_in), .o_inst(s_inst),
    .o_addr(s_addr), .o_err(s_err), .o_err_cnt(s_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  vec_t tbl[17];
  exp_t q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   exp_addr = 0;
  int   exp_ec = 0;
  int   exp_ec_s = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model of the output side, advanced on each observed handshake.
  always @(negedge clk) begin
    if (!reset && valid_out && ready_in) begin
      if (q.size() == 0) begin
        chk("spurious_word", q.size(), 1);
      end else begin
        mon_e = q.pop_front();
        chk("inst", inst, mon_e.inst);
        chk("err", err, mon_e.err);
        chk("addr", addr, exp_addr % 1024);
        chk("addr_small", s_addr, exp_addr % 4);
        chk("err_cnt", err_cnt, exp_ec);
        chk("err_cnt_small", s_err_cnt, exp_ec_s);
        if (mon_e.err) begin
          exp_ec   = (exp_ec < 255) ? exp_ec + 1 : 255;
          exp_ec_s = (exp_ec_s < 3) ? exp_ec_s + 1 : 3;
        end
        exp_addr++;
      end
    end
    if (!reset && clear) begin
      exp_addr = 0;
      exp_ec   = 0;
      exp_ec_s = 0;
    end
  end

  task automatic send(input vec_t v, output int waits);
    logic r;
    fmt = v.fmt; opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    f3 = v.f3; f7 = v.f7; imm = v.imm;
    valid_in = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      r = ready_out;
      @(posedge clk);
      #1;
      if (r) begin
        q.push_back('{v.inst, v.err});
        break;
      end
      waits++;
      if (waits > 50) begin
        chk("send_timeout", waits, 0);
        break;
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", q.size(), 0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    int wsum;
    tbl[0]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,        32'h00500093, 1'b0};
    tbl[1]  = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,        32'h0020A423, 1'b0};
    tbl[2]  = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0};
    tbl[3]  = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800, 32'h001000EF, 1'b0};
    tbl[4]  = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 32'h123452B7, 1'b0};
    tbl[5]  = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,        32'h402081B3, 1'b0};
    tbl[6]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF800, 32'h80000093, 1'b0};
    tbl[7]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2047,     32'h7FF00093, 1'b0};
    tbl[8]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,     32'h00000013, 1'b1};
    tbl[9]  = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3,        32'h00000013, 1'b1};
    tbl[10] = '{3'd7, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'd0,        32'h00000013, 1'b1};
    tbl[11] = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345001, 32'h00000013, 1'b1};
    tbl[12] = '{3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF00000, 32'h8000006F, 1'b0};
    tbl[13] = '{3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00100000, 32'h00000013, 1'b1};
    tbl[14] = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4094,     32'h7E000FE3, 1'b0};
    tbl[15] = '{3'd2, 7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'h00, 32'hFFFFFFFF, 32'hFE312FA3, 1'b0};
    tbl[16] = '{3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1,        32'h00000013, 1'b1};

    reset = 1'b1; clear = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; f3 = '0; f7 = '0; imm = '0;
    #12;
    chk("rst_valid", valid_out, 0);
    chk("rst_inst", inst, 0);
    chk("rst_addr", addr, 0);
    chk("rst_err", err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ready", ready_out, 1);

    // Two-cycle latency for the first word.
    @(posedge clk);
    #1;
    send(tbl[0], w);
    chk("lat_valid_c1", valid_out, 0);
    @(posedge clk);
    #1;
    chk("lat_valid_c2", valid_out, 1);
    chk("lat_inst", inst, 32'h00500093);
    chk("lat_addr", addr, 0);
    drain();
    pulse_clear();

    // Whole table back to back at full rate; small instance wraps its address.
    wsum = 0;
    for (int i = 1; i < 17; i++) begin
      send(tbl[i], w);
      wsum += w;
    end
    chk("stream_stalls", wsum, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("stream_rate", q.size(), 0);
    chk("final_err_cnt", err_cnt, 6);
    chk("final_err_cnt_sat", s_err_cnt, 3);
    chk("final_addr_wrap", s_addr, 3);
    pulse_clear();

    // Backpressure: two accepts, then stall with stable output.
    ready_in = 1'b0;
    send(tbl[1], w);
    send(tbl[2], w);
    chk("bp_ready_drop", ready_out, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_ready_low", ready_out, 0);
      chk("bp_valid_held", valid_out, 1);
      chk("bp_inst_held", inst, tbl[1].inst);
      chk("bp_addr_held", addr, 0);
    end
    ready_in = 1'b1;
    send(tbl[3], w);
    drain();

    // Clear coinciding with a handshake: the following word restarts at address 0.
    send(tbl[8], w);
    send(tbl[4], w);
    send(tbl[5], w);
    pulse_clear();
    chk("clear_addr", addr, 0);
    chk("clear_err_cnt", err_cnt, 0);
    chk("clear_inst", inst, tbl[5].inst);
    drain();

    // Reset with two words in flight.
    send(tbl[6], w);
    send(tbl[7], w);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_valid", valid_out, 0);
    chk("midrst_ready", ready_out, 1);
    q.delete();
    exp_addr = 0; exp_ec = 0; exp_ec_s = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("postrst_idle", valid_out, 0);
    send(tbl[3], w);
    @(posedge clk);
    #1;
    chk("postrst_addr", addr, 0);
    chk("postrst_inst", inst, tbl[3].inst);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Pipelined RISC-V RV32I instruction encoder, the inverse of the immediate generator.
- Takes decoded fields (format, opcode, registers, functs, full 32-bit immediate) and packs them into a 32-bit instruction word.
- Range-checks the immediate against the target format.
- Tags each output word with an incrementing instruction-memory word address, so a test/boot loader can stream programs into IMEM.
- Valid/ready on both sides; 2-stage pipeline.

Parameters:
- ADDR_W, 10, width of the output word-address counter (wraps at 2^ADDR_W).
- ERR_W, 8, width of the saturating error counter.

Ports:
- i_clk  input  1  clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_clear  input  1  synchronous clear of the address and error counters.
- i_valid  input  1  upstream field set valid.
- o_ready  output  1  encoder can accept a field set this cycle.
- i_fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- i_opcode  input  7  inst[6:0].
- i_rd  input  5  destination register.
- i_rs1  input  5  source register 1.
- i_rs2  input  5  source register 2.
- i_funct3  input  3  funct3 field.
- i_funct7  input  7  funct7 field (R only).
- i_imm  input  32  signed byte-offset / value immediate.
- o_valid  output  1  encoded word valid.
- i_ready  input  1  downstream accepts the word.
- o_inst  output  32  encoded instruction.
- o_addr  output  ADDR_W  IMEM word address for o_inst.
- o_err  output  1  the current o_inst was substituted because of an encode error.
- o_err_cnt  output  ERR_W  saturating count of errored words handed off.

Behaviour:
- Reset values:
  - o_valid=0, o_inst=0, o_addr=0, o_err=0, o_err_cnt=0.
  - Internal stage valids=0; o_ready=1 after reset deasserts.
- Input handshake: acceptance happens when i_valid && o_ready.
- Stage 1:
  - Registers all inputs.
  - Computes the legality flag err1 from the rules below.
- Stage 2:
  - Builds o_inst from the stage-1 registers.
  - Holds o_inst/o_err/o_addr stable while o_valid && !i_ready.
- Latency: 2 cycles from acceptance to o_valid when i_ready=1. Throughput is 1 word per cycle.
- Stall rules:
  - Stage 2 loads when !o_valid || i_ready.
  - Stage 1 advances when stage 2 loads.
  - o_ready = !s1_valid || stage-2-loads. This is combinational and must not depend on i_valid.
- Encoding (immediate bits taken from i_imm):
  - R: {funct7, rs2, rs1, f3, rd, op}
  - I: {imm[11:0], rs1, f3, rd, op}
  - S: {imm[11:5], rs2, rs1, f3, imm[4:0], op}
  - B: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}
  - U: {imm[31:12], rd, op}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
- Legality (err1=1 when violated):
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - R: always legal.
  - fmt 6/7: always error.
- On error: o_inst = 32'h0000_0013 (NOP), o_err=1. The word is still emitted and still consumes an address.
- Address counter:
  - o_addr is the counter value at stage-2 load.
  - The counter increments by 1 on each output handshake (o_valid && i_ready) and wraps from 2^ADDR_W-1 to 0.
- Error counter:
  - Increments on an output handshake with o_err=1.
  - Saturates at 2^ERR_W-1.
- i_clear:
  - Next-cycle address counter = 0 and o_err_cnt = 0.
  - Wins over a simultaneous handshake increment.
  - Does not flush pipeline data; an already-loaded o_addr keeps its value.
- Reset mid-operation: all in-flight words are dropped immediately (asynchronous). The first word after reset gets o_addr=0.

Test Plan:
- Accept fmt=I, op=0x13, rd=1, rs1=0, f3=0, imm=5 at cycle 0 with i_ready=1 -> o_valid at cycle 2, o_inst=0x00500093, o_addr=0, o_err=0.
- Stream back to back, i_ready=1:
  - S: op=0x23, rs1=1, rs2=2, f3=2, imm=8 -> 0x0020A423.
  - B: op=0x63, imm=-4 -> 0xFE000EE3.
  - J: op=0x6F, rd=1, imm=0x800 -> 0x001000EF.
  - U: op=0x37, rd=5, imm=0x12345000 -> 0x123452B7.
  - Required: consecutive cycles, o_addr 0,1,2,3.
- Errors:
  - I imm=2048 -> o_inst=0x00000013, o_err=1, o_err_cnt=1.
  - B imm=3 -> o_err=1, o_err_cnt=2.
  - fmt=7 -> o_err=1.
  - ERR_W=2 run with 5 errors -> o_err_cnt saturates at 3.
- Backpressure: hold i_ready=0 and offer 3 words -> o_ready drops after 2 accepts, o_inst held stable. Release i_ready -> words emerge in order with o_addr 0,1,2 and none lost or duplicated.
- Boundaries:
  - ADDR_W=2, emit 5 words -> o_addr 0,1,2,3,0.
  - i_clear asserted during a handshake -> next word o_addr=0 and o_err_cnt=0.
- Assert i_reset with 2 words in flight -> o_valid=0 the same cycle; after release, the next accepted word has o_addr=0.
